// File: rtl/bus_arbiter5_pkg.sv
// Shared types and constants for the five-way round-robin bus arbiter.
package bus_arbiter5_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

  localparam int N_REQ = 5;

  localparam logic [2:0] SEL_0 = 3'b000;
  localparam logic [2:0] SEL_1 = 3'b001;
  localparam logic [2:0] SEL_2 = 3'b010;
  localparam logic [2:0] SEL_3 = 3'b011;
  localparam logic [2:0] SEL_4 = 3'b100;

  // Index following i in the circular search order (4 wraps to 0).
  function automatic logic [2:0] next_idx(input logic [2:0] i);
    logic [2:0] r;
    case (i)
      SEL_0:   r = SEL_1;
      SEL_1:   r = SEL_2;
      SEL_2:   r = SEL_3;
      SEL_3:   r = SEL_4;
      default: r = SEL_0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bus_arbiter5_rr_pick5.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick5
  import bus_arbiter5_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic             found,
  output logic [2:0]       idx
);

  // Walk the offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = SEL_0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      int s;
      s = int'(ptr) + k;
      if (s >= N_REQ) s = s - N_REQ;
      if (req[s]) begin
        found = 1'b1;
        idx   = 3'(s);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter5.sv
// Round-robin arbiter driving the select of a 5:1 datapath mux, with hold timeout and drain cycle.
module bus_arbiter5
  import bus_arbiter5_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [2:0]       sel,
  output logic [N_REQ-1:0] grant,
  output logic             busy,
  output logic             timeout
);

  localparam int CW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

  state_t           state_reg;
  logic [2:0]       ptr_reg;
  logic [CW-1:0]    cnt_reg;
  logic [2:0]       sel_reg;
  logic [N_REQ-1:0] grant_reg;
  logic             busy_reg;
  logic             timeout_reg;

  logic       pick_found;
  logic [2:0] pick_idx;

  rr_pick5 u_pick (
    .req   (req),
    .ptr   (ptr_reg),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // grant_reg is one-hot while owning, so masking picks out the owner's bits.
  logic rel_done, rel_drop, rel_hold;
  assign rel_done = |(done & grant_reg);
  assign rel_drop = ~|(req & grant_reg);
  assign rel_hold = (HOLD_MAX != 0) && (32'(cnt_reg) == 32'(HOLD_MAX - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      ptr_reg     <= SEL_0;
      cnt_reg     <= '0;
      sel_reg     <= SEL_0;
      grant_reg   <= '0;
      busy_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          timeout_reg <= 1'b0;
          if (pick_found) begin
            state_reg <= GRANT;
            grant_reg <= N_REQ'(1) << pick_idx;
            sel_reg   <= pick_idx;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
          end else begin
            busy_reg <= 1'b0;
          end
        end
        GRANT: begin
          if (rel_done || rel_drop || rel_hold) begin
            state_reg   <= DRAIN;
            grant_reg   <= '0;
            ptr_reg     <= next_idx(sel_reg);
            // A voluntary release in the same cycle takes precedence over the timeout.
            timeout_reg <= rel_hold && !rel_done && !rel_drop;
          end else if (cnt_reg != '1) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DRAIN: begin
          state_reg   <= IDLE;
          busy_reg    <= 1'b0;
          timeout_reg <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          grant_reg <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign sel     = sel_reg;
  assign grant   = grant_reg;
  assign busy    = busy_reg;
  assign timeout = timeout_reg;

endmodule

// File: tb/tb_bus_arbiter5.sv
// Directed-vector bench for bus_arbiter5 with three HOLD_MAX settings sharing one stimulus.
module tb_bus_arbiter5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] req = '0;
  logic [4:0] done = '0;

  logic [2:0] sel8, sel4, sel3;
  logic [4:0] grant8, grant4, grant3;
  logic       busy8, busy4, busy3;
  logic       to8, to4, to3;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  bus_arbiter5 #(.HOLD_MAX(8)) dut8 (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .sel(sel8), .grant(grant8), .busy(busy8), .timeout(to8)
  );
  bus_arbiter5 #(.HOLD_MAX(4)) dut4 (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .sel(sel4), .grant(grant4), .busy(busy4), .timeout(to4)
  );
  bus_arbiter5 #(.HOLD_MAX(3)) dut3 (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .sel(sel3), .grant(grant3), .busy(busy3), .timeout(to3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req   = '0;
    done  = '0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  int order[6] = '{0, 1, 2, 3, 4, 0};

  initial begin
    logic [4:0] exp_g;

    // Reset values
    #3;
    check("rst_grant", grant8, 5'b00000);
    check("rst_sel", sel8, 3'd0);
    check("rst_busy", busy8, 1'b0);
    check("rst_timeout", to8, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Single request, release by done
    req = 5'b00100;
    tick();
    check("single_grant", grant8, 5'b00100);
    check("single_sel", sel8, 3'd2);
    check("single_busy", busy8, 1'b1);
    done = 5'b00100;
    tick();
    check("single_drain_grant", grant8, 5'b00000);
    check("single_drain_busy", busy8, 1'b1);
    check("single_drain_sel", sel8, 3'd2);
    done = 5'b00000;
    req  = 5'b00000;
    tick();
    check("single_idle_busy", busy8, 1'b0);
    check("single_idle_grant", grant8, 5'b00000);

    // Asynchronous reset in the middle of a grant
    do_reset();
    req = 5'b00100;
    tick();
    check("arst_pre_grant", grant8, 5'b00100);
    #2 reset = 1'b1;
    #1;
    check("arst_grant", grant8, 5'b00000);
    check("arst_sel", sel8, 3'd0);
    check("arst_busy", busy8, 1'b0);
    #1 reset = 1'b0;
    req = 5'b00001;
    tick();
    check("arst_regrant", grant8, 5'b00001);
    check("arst_regrant_sel", sel8, 3'd0);

    // Fairness with every requester active
    do_reset();
    req = 5'b11111;
    for (int n = 0; n < 6; n++) begin
      exp_g = 5'b00001 << order[n];
      tick();
      check("fair_grant", grant8, exp_g);
      check("fair_sel", sel8, order[n]);
      tick();
      check("fair_hold", grant8, exp_g);
      done = exp_g;
      tick();
      check("fair_drain_grant", grant8, 5'b00000);
      check("fair_drain_busy", busy8, 1'b1);
      done = 5'b00000;
      tick();
      check("fair_idle_busy", busy8, 1'b0);
    end

    // Release by request drop
    do_reset();
    req = 5'b01000;
    tick();
    check("drop_grant", grant8, 5'b01000);
    req = 5'b00000;
    tick();
    check("drop_drain_grant", grant8, 5'b00000);
    check("drop_drain_timeout", to8, 1'b0);

    // Timeout with HOLD_MAX = 4
    do_reset();
    req = 5'b01000;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("to_grant_held", grant4, 5'b01000);
      check("to_no_pulse", to4, 1'b0);
    end
    tick();
    check("to_drain_grant", grant4, 5'b00000);
    check("to_pulse", to4, 1'b1);
    check("to_drain_busy", busy4, 1'b1);
    tick();
    check("to_idle_pulse", to4, 1'b0);
    check("to_idle_busy", busy4, 1'b0);
    tick();
    check("to_regrant", grant4, 5'b01000);
    check("to_regrant_sel", sel4, 3'd3);

    // Wrap from owner 4 and non-owner done
    do_reset();
    req = 5'b10000;
    tick();
    check("wrap_owner4", grant8, 5'b10000);
    req  = 5'b10001;
    done = 5'b00001;
    tick();
    check("wrap_nonowner_done", grant8, 5'b10000);
    check("wrap_nonowner_sel", sel8, 3'd4);
    done = 5'b10000;
    tick();
    check("wrap_drain_grant", grant8, 5'b00000);
    check("wrap_drain_sel", sel8, 3'd4);
    done = 5'b00000;
    tick();
    check("wrap_idle_grant", grant8, 5'b00000);
    tick();
    check("wrap_next_grant", grant8, 5'b00001);
    check("wrap_next_sel", sel8, 3'd0);

    // done on the timeout cycle with HOLD_MAX = 3
    do_reset();
    req = 5'b00010;
    tick();
    check("sim_grant_c0", grant3, 5'b00010);
    tick();
    check("sim_grant_c1", grant3, 5'b00010);
    tick();
    check("sim_grant_c2", grant3, 5'b00010);
    done = 5'b00010;
    tick();
    check("sim_drain_grant", grant3, 5'b00000);
    check("sim_no_timeout", to3, 1'b0);
    done = 5'b00000;
    req  = 5'b00000;
    tick();
    check("sim_idle_timeout", to3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bus_arbiter5.md
# bus_arbiter5

Round-robin arbiter that shares one 32-bit datapath source port among five requesters by driving the 3-bit select of the 5:1 datapath multiplexer. It sits between the requesting units and the mux. It grants one requester at a time, holds the grant until release or timeout, then inserts a drain cycle before re-arbitrating. Select encoding is the mux encoding: requester i ↔ sel = i, 0..4.

## Interface
- HOLD_MAX, default 8, maximum consecutive GRANT cycles per owner; 0 disables timeout.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  5  request vector, bit i = requester i; level, held until served.
- done  input  5  release vector; only the current owner's bit is honoured.
- sel  output  3  mux select, registered; always in 0..4.
- grant  output  5  one-hot grant, registered; all-zero when no owner.
- busy  output  1  high in GRANT and DRAIN.
- timeout  output  1  one-cycle pulse when an owner is forcibly released.

## Operation
- States: IDLE, GRANT, DRAIN.
- Pointer ptr (0..4): the first index searched. Search order is ptr, ptr+1, …, wrapping 4→0.
- IDLE:
  - If req ≠ 0, choose the winner w = first set bit in the search order.
  - Next state GRANT; grant = one-hot(w), sel = w; hold counter cleared.
  - If req = 0, stay in IDLE.
- GRANT:
  - sel and grant are stable; the hold counter increments each cycle.
  - Release conditions, evaluated each edge:
    - done[owner] = 1;
    - req[owner] = 0;
    - counter = HOLD_MAX−1 with HOLD_MAX ≠ 0. This is a timeout release.
  - On release: next state DRAIN, grant = 0, ptr = owner+1 (4 wraps to 0).
- DRAIN:
  - Exactly one cycle; grant = 0, sel keeps the old owner.
  - Next state IDLE.
- Boundary rules:
  - done for a non-owner is ignored. done for a non-owner while in IDLE is ignored.
  - done and the req drop in the same cycle count as a single release.
  - done and timeout in the same cycle: a normal release, with no timeout pulse.
  - A requester that drops req before being granted is simply skipped.
  - sel never takes values 5..7. The mux has no defined output for them.
  - grant is never multi-hot.
- Reset, asynchronous, any state: state = IDLE, grant = 0, sel = 0, ptr = 0, counter = 0, busy = 0, timeout = 0. A grant in progress is abandoned with no drain.

## Timing
- Arbitration latency: req sampled at edge k, so grant/sel are valid after edge k.
- Release: done sampled at edge k drops grant after edge k (DRAIN). IDLE follows after edge k+1. The earliest new grant is after edge k+2.
- Dead time between owners is 2 cycles minimum: DRAIN, then IDLE.
- timeout is asserted for exactly the DRAIN cycle that follows a forced release.
- Counter width is clog2(HOLD_MAX+1) and it saturates, never wraps.
- All outputs are registered; there is no combinational path from req/done to the outputs.

## Structure
- Shared package:
  - state enum {IDLE, GRANT, DRAIN};
  - constant N_REQ = 5;
  - select constants SEL_0..SEL_4 = 3'b000..3'b100.
- Sub-module rr_pick5: combinational. Inputs req[4:0] and ptr[2:0]. Outputs found and idx[2:0], the first set bit at or after ptr with wrap.
- Top level holds the FSM, ptr, counter and output registers.

## Test plan
- Reset: assert reset mid-GRANT (owner 2) → same cycle grant = 0, sel = 0, busy = 0. After release, req = 00001 → grant = 00001 one edge later.
- Single request: req = 00100 → after 1 edge grant = 00100, sel = 2. Pulse done[2] → grant = 0 next cycle, busy high one more cycle, then IDLE.
- Fairness: req = 11111 held, done pulsed on each owner's 2nd GRANT cycle → owner order 0,1,2,3,4,0. Every sel is in 0..4 and grant is always one-hot.
- Timeout: HOLD_MAX = 4, req = 01000 held, done = 0 → grant high exactly 4 cycles. timeout pulses once in DRAIN, then owner 3 is re-granted since it is still the only request.
- Wrap plus non-owner done: owner 4, done = 00001 → grant unchanged. Then done = 10000 with req = 10001 → next owner 0, sel = 0.
- Simultaneous release: HOLD_MAX = 3, done[owner] asserted on the cycle where the counter = 2 → released, timeout stays 0.
